nios_system_sysid_checker: RTL and testbench
============================================

Name: nios_system_sysid_checker

Overview:
- Avalon-MM read master that sequences a boot-time identity check of the system ID slave.
- Reads word 0 (system ID) and then word 1 (build timestamp), and compares each against parameterised expected values.
- Exposes done, pass/fail and timeout status to the reset/boot controller and to a status CSR.
- Sits between the system interconnect and the boot logic; at most one read is outstanding at any time.

Parameters:
- EXPECTED_ID, 0, value required at sysid word 0.
- EXPECTED_TIMESTAMP, 1581593513, value required at sysid word 1.
- TIMEOUT_CYCLES, 256, maximum cycles a single read may spend in REQ+WAIT before it is aborted; range 2..65535.
- MAX_RETRIES, 2, number of full-sequence restarts after a timeout; range 0..255.
- AUTO_START, 1, when 1 a check launches automatically after reset.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to run a check; honoured only in IDLE or DONE.
- avm_address  out  1  word select: 0 = ID, 1 = timestamp.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data qualifier.
- busy  out  1  check in progress.
- done  out  1  check finished; held until the next start.
- id_ok  out  1  captured ID == EXPECTED_ID.
- ts_ok  out  1  captured timestamp == EXPECTED_TIMESTAMP.
- timed_out  out  1  retries exhausted.
- captured_id  out  32  last ID read.
- captured_ts  out  32  last timestamp read.
- retry_count  out  8  timeouts taken during the current check.

Behaviour:
- Reset, asynchronous: state = IDLE; every output and internal counter = 0.
- Reset asserted mid-transaction abandons the transaction immediately; no read is reissued until reset is released.
- States: IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, CHECK, DONE.
- IDLE:
  - Moves to REQ_ID on start.
  - With AUTO_START=1, also moves to REQ_ID unconditionally on the first clock after reset release.
- Entering REQ_ID from IDLE/DONE clears done, id_ok, ts_ok, timed_out, retry_count, captured_id and captured_ts.
- REQ_x:
  - avm_read=1; avm_address=0 (ID) or 1 (TS), held stable while avm_waitrequest=1.
  - Read is accepted on a clock edge with avm_waitrequest=0, and the state moves to WAIT_x.
  - If avm_readdatavalid=1 in that same accept cycle, data is captured and the state skips directly to the next REQ or CHECK.
- WAIT_x: avm_read=0; on avm_readdatavalid=1, capture avm_readdata into captured_id/captured_ts and advance (WAIT_ID -> REQ_TS, WAIT_TS -> CHECK).
- avm_readdatavalid in any other state is ignored, including late data from an aborted read.
- Timeout counter (16 bit):
  - Cleared on entry to each REQ_x; increments every cycle in REQ_x/WAIT_x.
  - Timeout event: counter == TIMEOUT_CYCLES-1 and the read does not complete that cycle. Completion in the same cycle wins over timeout.
  - On a timeout event with retry_count < MAX_RETRIES: retry_count++ and return to REQ_ID; captured values are retained until overwritten.
  - On a timeout event otherwise: timed_out=1, id_ok=ts_ok=0, go to DONE.
- CHECK: one cycle; id_ok and ts_ok are registered from 32-bit equality compares; go to DONE. A compare mismatch is final and is never retried.
- DONE: done=1. start returns to REQ_ID.
- busy=1 in REQ_x, WAIT_x and CHECK.
- start while busy is ignored.
- Latency, zero-wait slave with readdatavalid one cycle after accept: first avm_read cycle = c0; done=1 from c5.

Test Plan:
- Zero-wait slave returns 0 then 1581593513, readdatavalid 1 cycle after accept -> reads at addresses 0, 1; done at c5; id_ok=1, ts_ok=1, retry_count=0.
- Slave holds waitrequest 3 cycles per read, returns ID 0x12345678 -> avm_address/avm_read stable while stalled; done=1, id_ok=0, ts_ok=1, captured_id=0x12345678.
- TIMEOUT_CYCLES=8, MAX_RETRIES=2, slave never asserts readdatavalid -> two retries (retry_count=2), then done=1, timed_out=1 at 3×8 cycles of read activity.
- First ID read times out; a late readdatavalid with 0xDEAD arrives during the retry's REQ_ID; the retry then succeeds -> stale data ignored, captured_id=0, retry_count=1, id_ok=1.
- readdatavalid in the accept cycle at counter == TIMEOUT_CYCLES-1 -> completion taken, no retry.
- reset_n pulsed low while in WAIT_TS, then start with AUTO_START=0 -> all outputs 0 during reset; stays IDLE until start; fresh sequence begins at address 0.

Source files
------------

// File: rtl/nios_system_sysid_checker.sv
// ---------------------------------------------------------------------------
// nios_system_sysid_checker
//
// Boot-time identity check of the system ID slave. Acts as an Avalon-MM read
// master: reads word 0 (system ID), then word 1 (build timestamp), compares
// both against parameterised expected values and reports the result to the
// boot controller / status CSR. At most one read is outstanding.
//
// Ports:
//   clock, reset_n        system clock, async active-low reset
//   start                 1-cycle launch request (honoured in IDLE/DONE only)
//   avm_address/avm_read  read request, word select 0 = ID, 1 = timestamp
//   avm_waitrequest       slave stall
//   avm_readdata/valid    read response
//   busy                  check in progress (REQ/WAIT/CHECK)
//   done                  check finished, held until next start
//   id_ok, ts_ok          compare results
//   timed_out             all retries exhausted
//   captured_id/ts        last words read
//   retry_count           timeouts taken during the current check
// ---------------------------------------------------------------------------
module nios_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1581593513,
    parameter int          TIMEOUT_CYCLES     = 256,
    parameter int          MAX_RETRIES        = 2,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timed_out,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts,
    output logic [7:0]  retry_count
);

    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ_ID, S_WAIT_ID, S_REQ_TS, S_WAIT_TS, S_CHECK, S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] tmo_cnt;
    logic        in_req, in_wait, rd_done, tmo_hit, do_retry, launch, enter_req;

    always_comb begin
        in_req   = (state == S_REQ_ID)  || (state == S_REQ_TS);
        in_wait  = (state == S_WAIT_ID) || (state == S_WAIT_TS);
        // Data only counts in the accept cycle of a REQ or in a WAIT; a late
        // response from an aborted read arriving while stalled is dropped.
        rd_done  = (in_req && !avm_waitrequest && avm_readdatavalid) ||
                   (in_wait && avm_readdatavalid);
        // Completion in the final cycle beats the timeout.
        tmo_hit  = (in_req || in_wait) && (tmo_cnt == TMO_LAST) && !rd_done;
        do_retry = tmo_hit && (retry_count < RETRY_MAX);
        // IDLE is only reachable from reset, so AUTO_START simply makes the
        // first post-reset clock launch a check.
        launch   = ((state == S_IDLE) && (start || AUTO_START)) ||
                   ((state == S_DONE) && start);

        state_nxt = state;
        if (tmo_hit) begin
            state_nxt = do_retry ? S_REQ_ID : S_DONE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (launch) state_nxt = S_REQ_ID;
                S_REQ_ID:  if (!avm_waitrequest)
                               state_nxt = avm_readdatavalid ? S_REQ_TS : S_WAIT_ID;
                S_WAIT_ID: if (avm_readdatavalid) state_nxt = S_REQ_TS;
                S_REQ_TS:  if (!avm_waitrequest)
                               state_nxt = avm_readdatavalid ? S_CHECK : S_WAIT_TS;
                S_WAIT_TS: if (avm_readdatavalid) state_nxt = S_CHECK;
                S_CHECK:   state_nxt = S_DONE;
                default:   state_nxt = S_IDLE;
            endcase
        end

        // A retry re-enters REQ_ID from REQ_ID, so a same-state transition
        // caused by a timeout also restarts the counter.
        enter_req = ((state_nxt == S_REQ_ID) || (state_nxt == S_REQ_TS)) &&
                    ((state_nxt != state) || tmo_hit);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            tmo_cnt     <= '0;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timed_out   <= 1'b0;
            captured_id <= '0;
            captured_ts <= '0;
            retry_count <= '0;
        end else begin
            state <= state_nxt;

            // Outputs registered from the next state so they line up with it.
            avm_read    <= (state_nxt == S_REQ_ID) || (state_nxt == S_REQ_TS);
            avm_address <= (state_nxt == S_REQ_TS);
            busy        <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
            done        <= (state_nxt == S_DONE);

            if (enter_req)
                tmo_cnt <= '0;
            else if (in_req || in_wait)
                tmo_cnt <= tmo_cnt + 16'd1;

            if (launch) begin
                id_ok       <= 1'b0;
                ts_ok       <= 1'b0;
                timed_out   <= 1'b0;
                retry_count <= '0;
                captured_id <= '0;
                captured_ts <= '0;
            end

            if (rd_done) begin
                if ((state == S_REQ_ID) || (state == S_WAIT_ID))
                    captured_id <= avm_readdata;
                else
                    captured_ts <= avm_readdata;
            end

            if (tmo_hit) begin
                if (do_retry) begin
                    retry_count <= retry_count + 8'd1;
                end else begin
                    timed_out <= 1'b1;
                    id_ok     <= 1'b0;
                    ts_ok     <= 1'b0;
                end
            end

            if (state == S_CHECK) begin
                id_ok <= (captured_id == EXPECTED_ID);
                ts_ok <= (captured_ts == EXPECTED_TIMESTAMP);
            end
        end
    end

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
module tb_nios_system_sysid_checker;

    localparam logic [31:0] TS = 32'd1581593513;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address, avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        busy, done, id_ok, ts_ok, timed_out;
    logic [31:0] captured_id, captured_ts;
    logic [7:0]  retry_count;

    // second instance with default parameters, exercising AUTO_START=1
    logic        aa_addr, aa_read, aa_busy, aa_done, aa_id_ok, aa_ts_ok, aa_tmo;
    logic        aa_wr = 1'b0;
    logic        aa_rdv = 1'b0;
    logic [31:0] aa_rdata = '0;
    logic [31:0] aa_cid, aa_cts;
    logic [7:0]  aa_rc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    nios_system_sysid_checker #(
        .TIMEOUT_CYCLES(8), .MAX_RETRIES(2), .AUTO_START(1'b0)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok),
        .timed_out(timed_out), .captured_id(captured_id),
        .captured_ts(captured_ts), .retry_count(retry_count)
    );

    nios_system_sysid_checker u_auto (
        .clock(clock), .reset_n(reset_n), .start(1'b0),
        .avm_address(aa_addr), .avm_read(aa_read),
        .avm_waitrequest(aa_wr), .avm_readdata(aa_rdata),
        .avm_readdatavalid(aa_rdv),
        .busy(aa_busy), .done(aa_done), .id_ok(aa_id_ok), .ts_ok(aa_ts_ok),
        .timed_out(aa_tmo), .captured_id(aa_cid),
        .captured_ts(aa_cts), .retry_count(aa_rc)
    );

    // ---------------- slave model + address scoreboard (main DUT) ----------
    logic        exp_addr[$];
    int          cfg_wait = 0;
    int          mute_n   = 0;
    bit          cfg_same = 0;
    bit          late_arm = 0;
    logic [31:0] cfg_data [2];
    bit          pend = 0;
    logic [31:0] pend_data = '0;
    int          stall = 0;

    initial begin
        logic a;
        forever begin
            @(negedge clock);
            avm_readdatavalid = 1'b0;
            avm_waitrequest   = 1'b0;
            if (!reset_n) begin
                pend  = 0;
                stall = 0;
            end else begin
                if (pend) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = pend_data;
                    pend              = 0;
                end
                if (avm_read) begin
                    if (stall < cfg_wait) begin
                        avm_waitrequest = 1'b1;
                        stall++;
                        if (late_arm && mute_n == 0) begin
                            avm_readdatavalid = 1'b1;
                            avm_readdata      = 32'h0000DEAD;
                            late_arm          = 0;
                        end
                    end else begin
                        stall = 0;
                        n_tests++;
                        if (exp_addr.size() == 0) begin
                            n_fail++;
                            $display("FAIL sb_unexpected_read addr=%0d required=none", avm_address);
                        end else begin
                            a = exp_addr.pop_front();
                            if (avm_address !== a) begin
                                n_fail++;
                                $display("FAIL sb_read_addr got=%0d required=%0d", avm_address, a);
                            end
                        end
                        if (mute_n > 0) mute_n--;
                        else if (cfg_same) begin
                            avm_readdatavalid = 1'b1;
                            avm_readdata      = cfg_data[avm_address];
                        end else begin
                            pend      = 1;
                            pend_data = cfg_data[avm_address];
                        end
                    end
                end
            end
        end
    end

    // zero-wait slave for the auto-start instance
    initial begin
        bit aa_pend, aa_paddr;
        aa_pend = 0; aa_paddr = 0;
        forever begin
            @(negedge clock);
            aa_rdv = 1'b0;
            if (!reset_n) begin
                aa_pend = 0;
            end else begin
                if (aa_pend) begin
                    aa_rdv   = 1'b1;
                    aa_rdata = aa_paddr ? TS : 32'd0;
                    aa_pend  = 0;
                end
                if (aa_read) begin
                    aa_pend  = 1;
                    aa_paddr = aa_addr;
                end
            end
        end
    end

    // ---------------- helpers (no checking) --------------------------------
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    // ---------------- tests -------------------------------------------------
    task automatic test_reset();
        tick();
        n_tests++;
        if ({avm_read, avm_address, busy, done, id_ok, ts_ok, timed_out,
             captured_id, captured_ts, retry_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got nonzero busy=%b done=%b read=%b required=all 0",
                     busy, done, avm_read);
        end
        n_tests++;
        if ({aa_read, aa_busy, aa_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_auto_outputs got=%b required=000", {aa_read, aa_busy, aa_done});
        end
    endtask

    task automatic test_autostart();
        int cyc;
        reset_n = 1'b1;
        tick();
        n_tests++;
        if (aa_read !== 1'b1 || aa_addr !== 1'b0 || avm_read !== 1'b0) begin
            n_fail++;
            $display("FAIL autostart_launch got aa_read=%b main_read=%b required 1/0", aa_read, avm_read);
        end
        cyc = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (aa_done === 1'b1) begin cyc = i; break; end
        end
        n_tests++;
        if (cyc != 5 || aa_id_ok !== 1'b1 || aa_ts_ok !== 1'b1 || aa_cts !== TS) begin
            n_fail++;
            $display("FAIL autostart_result got cyc=%0d id_ok=%b ts_ok=%b required 5/1/1", cyc, aa_id_ok, aa_ts_ok);
        end
    endtask

    task automatic test_basic();
        int cyc;
        cfg_wait = 0; cfg_same = 0; mute_n = 0;
        cfg_data[0] = 32'd0; cfg_data[1] = TS;
        exp_addr.push_back(1'b0); exp_addr.push_back(1'b1);
        pulse_start();
        n_tests++;
        if (avm_read !== 1'b1 || avm_address !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_c0 got read=%b addr=%b busy=%b required 1/0/1", avm_read, avm_address, busy);
        end
        wait_done(cyc);
        n_tests++;
        if (cyc != 5) begin
            n_fail++;
            $display("FAIL basic_latency got=%0d required=5", cyc);
        end
        n_tests++;
        if (id_ok !== 1'b1 || ts_ok !== 1'b1 || retry_count !== 8'd0 || timed_out !== 1'b0 ||
            captured_ts !== TS || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result got id_ok=%b ts_ok=%b rc=%0d to=%b ts=%h required 1/1/0/0/%h",
                     id_ok, ts_ok, retry_count, timed_out, captured_ts, TS);
        end
    endtask

    task automatic test_waitstate();
        bit   prev_stall = 0;
        logic prev_addr  = 0;
        int   bad = 0;
        cfg_wait = 3; cfg_data[0] = 32'h12345678; cfg_data[1] = TS;
        exp_addr.push_back(1'b0); exp_addr.push_back(1'b1);
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            if (prev_stall && (avm_read !== 1'b1 || avm_address !== prev_addr)) bad++;
            prev_stall = avm_read && avm_waitrequest;
            prev_addr  = avm_address;
            if (done === 1'b1) break;
            tick();
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL wait_stable got %0d unstable cycles required=0", bad);
        end
        n_tests++;
        if (done !== 1'b1 || id_ok !== 1'b0 || ts_ok !== 1'b1 || captured_id !== 32'h12345678) begin
            n_fail++;
            $display("FAIL wait_result got done=%b id_ok=%b ts_ok=%b id=%h required 1/0/1/12345678",
                     done, id_ok, ts_ok, captured_id);
        end
    endtask

    task automatic test_timeout();
        int busy_cnt = 1;
        int cyc = -1;
        cfg_wait = 0; mute_n = 1000;
        cfg_data[0] = 32'd0; cfg_data[1] = TS;
        exp_addr.push_back(1'b0); exp_addr.push_back(1'b0); exp_addr.push_back(1'b0);
        pulse_start();
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (done === 1'b1) begin cyc = i; break; end
            if (busy === 1'b1) busy_cnt++;
        end
        mute_n = 0;
        n_tests++;
        if (cyc != 24 || busy_cnt != 24) begin
            n_fail++;
            $display("FAIL timeout_cycles got done_at=%0d busy=%0d required 24/24", cyc, busy_cnt);
        end
        n_tests++;
        if (timed_out !== 1'b1 || retry_count !== 8'd2 || id_ok !== 1'b0 || ts_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_result got to=%b rc=%0d id_ok=%b required 1/2/0", timed_out, retry_count, id_ok);
        end
        n_tests++;
        if (exp_addr.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_reads got %0d missing required=0", exp_addr.size());
            exp_addr.delete();
        end
    endtask

    task automatic test_late_data();
        int cyc;
        cfg_wait = 2; mute_n = 1; late_arm = 1;
        cfg_data[0] = 32'd0; cfg_data[1] = TS;
        exp_addr.push_back(1'b0); exp_addr.push_back(1'b0); exp_addr.push_back(1'b1);
        pulse_start();
        wait_done(cyc);
        n_tests++;
        if (late_arm !== 1'b0) begin
            n_fail++;
            $display("FAIL late_injected got armed=%b required=0", late_arm);
            late_arm = 0;
        end
        n_tests++;
        if (done !== 1'b1 || captured_id !== 32'd0 || retry_count !== 8'd1 || id_ok !== 1'b1 ||
            ts_ok !== 1'b1 || timed_out !== 1'b0) begin
            n_fail++;
            $display("FAIL late_result got id=%h rc=%0d id_ok=%b ts_ok=%b required 0/1/1/1",
                     captured_id, retry_count, id_ok, ts_ok);
        end
    endtask

    task automatic test_edge_complete();
        int cyc;
        cfg_wait = 7; cfg_same = 1;
        cfg_data[0] = 32'd0; cfg_data[1] = TS;
        exp_addr.push_back(1'b0); exp_addr.push_back(1'b1);
        pulse_start();
        wait_done(cyc);
        cfg_same = 0;
        n_tests++;
        if (done !== 1'b1 || retry_count !== 8'd0 || timed_out !== 1'b0 || id_ok !== 1'b1 ||
            ts_ok !== 1'b1 || captured_ts !== TS) begin
            n_fail++;
            $display("FAIL edge_complete got rc=%0d to=%b id_ok=%b ts_ok=%b required 0/0/1/1",
                     retry_count, timed_out, id_ok, ts_ok);
        end
        n_tests++;
        if (exp_addr.size() != 0) begin
            n_fail++;
            $display("FAIL edge_reads got %0d missing required=0", exp_addr.size());
            exp_addr.delete();
        end
    endtask

    task automatic test_reset_midflight();
        int cyc;
        int bad = 0;
        cfg_wait = 0;
        cfg_data[0] = 32'd0; cfg_data[1] = TS;
        exp_addr.push_back(1'b0); exp_addr.push_back(1'b1);
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            if (avm_read && avm_address && !avm_waitrequest) break;
            tick();
        end
        tick();  // now in WAIT_TS
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({avm_read, avm_address, busy, done, id_ok, ts_ok, timed_out,
             captured_id, captured_ts, retry_count} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs got busy=%b id=%h required all 0", busy, captured_id);
        end
        tick(); tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (avm_read !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL midreset_idle got %0d active cycles required=0", bad);
        end
        exp_addr.push_back(1'b0); exp_addr.push_back(1'b1);
        pulse_start();
        n_tests++;
        if (avm_read !== 1'b1 || avm_address !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_restart got read=%b addr=%b required 1/0", avm_read, avm_address);
        end
        wait_done(cyc);
        n_tests++;
        if (cyc != 5 || id_ok !== 1'b1 || ts_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_result got cyc=%0d id_ok=%b ts_ok=%b required 5/1/1", cyc, id_ok, ts_ok);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_autostart();
        test_basic();
        test_waitstate();
        test_timeout();
        test_late_data();
        test_edge_complete();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
